resize_pixel_writer: RTL and testbench
======================================

RESIZE_PIXEL_WRITER -- requirements
Module: resize_pixel_writer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH_8, default 8, giving the pixel width.
REQ-002 The block SHALL have parameter DATA_WIDTH_12, default 12, giving the coordinate and dimension width.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 20, giving the destination buffer address width.
REQ-004 Port clk_os, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port reset, input, 1 bit: reset is asynchronous and active-high.
REQ-006 Port i_start, input, 1 bit: single-cycle frame-start pulse.
REQ-007 Port dst_width, input, DATA_WIDTH_12: destination width, sampled at start.
REQ-008 Port dst_height, input, DATA_WIDTH_12: destination height, sampled at start.
REQ-009 Port i_pixel_valid, input, 1 bit: source pixel present this cycle.
REQ-010 Port i_pixel, input, DATA_WIDTH_8: source pixel value.
REQ-011 Port i_isreach, input, 1 bit: the source coordinate maps to the current destination coordinate (from the resize coordinate stage).
REQ-012 Port o_wr_en, output, 1 bit: destination buffer write strobe.
REQ-013 Port o_wr_addr, output, ADDR_WIDTH: destination buffer write address.
REQ-014 Port o_wr_data, output, DATA_WIDTH_8: destination buffer write data.
REQ-015 Port o_busy, output, 1 bit: a frame is in progress.
REQ-016 Port o_frame_done, output, 1 bit: one-cycle pulse after the last destination pixel is written.
REQ-017 Port o_error, output, 1 bit: sticky flag for a start request with a zero or out-of-range dimension.

Function
REQ-018 The state machine SHALL have three states: IDLE, COLLECT and DONE.
REQ-019 In IDLE, i_start with non-zero dimensions whose product fits in 2^ADDR_WIDTH SHALL latch both dimensions, clear the x, y and address counters, and go to COLLECT.
REQ-020 An i_start that fails REQ-019 SHALL set o_error and leave the state in IDLE.
REQ-021 In COLLECT, a cycle with i_pixel_valid and i_isreach both high is an accepted sample.
REQ-022 An accepted sample SHALL drive o_wr_en=1, o_wr_data=i_pixel and o_wr_addr=current address on the next cycle (latency 1).
REQ-023 After each accepted sample, x SHALL increment, and the address SHALL increment by 1.
REQ-024 When x equals width-1 on an accepted sample, x SHALL wrap to 0 and y SHALL increment.
REQ-025 An accepted sample at x=width-1 and y=height-1 SHALL cause a transition to DONE.
REQ-026 DONE SHALL last one cycle, assert o_frame_done, and return to IDLE.
REQ-027 i_start in COLLECT SHALL restart the frame per REQ-019 or REQ-020; an invalid restart SHALL also return the state to IDLE.
REQ-028 A sample in the same cycle as i_start SHALL be dropped.
REQ-029 Samples while in IDLE or DONE SHALL be ignored.
REQ-030 o_busy SHALL be 1 exactly in COLLECT.
REQ-031 Address arithmetic SHALL be unsigned ADDR_WIDTH bits; with REQ-019 enforced it never wraps.
REQ-032 o_error SHALL clear only on reset or on a subsequent valid i_start.

Reset
REQ-033 Reset SHALL force state IDLE, all counters and latched dimensions to 0, and o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done and o_error to 0, immediately.
REQ-034 Reset mid-frame SHALL abandon the frame with no o_frame_done pulse.
REQ-035 After reset release, the block SHALL accept a new i_start on the next rising edge.

Structure
REQ-036 A shared package SHALL hold the state encoding and the default width constants (8, 12, 20).
REQ-037 One sub-module, resize_addr_counter, SHALL hold the x/y/address counters with clear and advance inputs and a last-pixel output.
REQ-038 The FSM and output registers SHALL stay in the top module.

Verification
REQ-039 Scenario 4x2 frame, 8 samples of 0x10..0x17 -> writes to addresses 0..7 with matching data, each one cycle after its sample, then o_frame_done one cycle later, then o_busy=0.
REQ-040 Scenario valid high with isreach toggling every other cycle on a 2x2 frame -> exactly 4 writes, at addresses 0..3.
REQ-041 Scenario i_start with dst_width=0 -> o_error=1, state stays IDLE, no writes; a following valid start -> o_error=0.
REQ-042 Scenario restart after 3 samples of a 4x4 frame -> the next sample is written to address 0, and no frame_done pulse for the aborted frame.
REQ-043 Scenario reset asserted mid-COLLECT -> outputs are 0 asynchronously, with no frame_done pulse.
REQ-044 Scenario i_start coincident with a sample -> the sample is not written, and the first write goes to address 0 from the next sample.

Source files
------------

// File: rtl/resize_pixel_writer_pkg.sv
// Shared state encoding and default widths for the resize pixel writer.
package resize_pixel_writer_pkg;

  localparam int DEF_DATA_WIDTH_8  = 8;
  localparam int DEF_DATA_WIDTH_12 = 12;
  localparam int DEF_ADDR_WIDTH    = 20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/resize_pixel_writer_if.sv
// Frame control, source pixel stream and destination write bus of the writer.
interface resize_pixel_writer_if #(
  parameter int DATA_WIDTH_8  = 8,
  parameter int DATA_WIDTH_12 = 12,
  parameter int ADDR_WIDTH    = 20
);
  logic                     i_start;
  logic [DATA_WIDTH_12-1:0] dst_width;
  logic [DATA_WIDTH_12-1:0] dst_height;
  logic                     i_pixel_valid;
  logic [DATA_WIDTH_8-1:0]  i_pixel;
  logic                     i_isreach;
  logic                     o_wr_en;
  logic [ADDR_WIDTH-1:0]    o_wr_addr;
  logic [DATA_WIDTH_8-1:0]  o_wr_data;
  logic                     o_busy;
  logic                     o_frame_done;
  logic                     o_error;

  modport master (
    output i_start, dst_width, dst_height, i_pixel_valid, i_pixel, i_isreach,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_error
  );

  modport slave (
    input  i_start, dst_width, dst_height, i_pixel_valid, i_pixel, i_isreach,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_frame_done, o_error
  );
endinterface

// File: rtl/resize_addr_counter.sv
// Destination raster position (x, y) and linear write address for one frame.
module resize_addr_counter #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int ADDR_WIDTH    = 20
) (
  input  logic                     clk_os,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     advance,
  input  logic [DATA_WIDTH_12-1:0] width,
  input  logic [DATA_WIDTH_12-1:0] height,
  output logic [ADDR_WIDTH-1:0]    addr,
  output logic                     last
);

  logic [DATA_WIDTH_12-1:0] x;
  logic [DATA_WIDTH_12-1:0] y;
  logic                     x_end;

  assign x_end = (x == width - DATA_WIDTH_12'(1));
  assign last  = x_end && (y == height - DATA_WIDTH_12'(1));

  always_ff @(posedge clk_os or posedge reset) begin
    if (reset) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + ADDR_WIDTH'(1);
      if (x_end) begin
        x <= '0;
        y <= y + DATA_WIDTH_12'(1);
      end else begin
        x <= x + DATA_WIDTH_12'(1);
      end
    end
  end

endmodule

// File: rtl/resize_pixel_writer.sv
// Writes resize-accepted source pixels into a raster-ordered destination buffer.
module resize_pixel_writer
  import resize_pixel_writer_pkg::*;
#(
  parameter int DATA_WIDTH_8  = DEF_DATA_WIDTH_8,
  parameter int DATA_WIDTH_12 = DEF_DATA_WIDTH_12,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH
) (
  input  logic                clk_os,
  input  logic                reset,
  resize_pixel_writer_if.slave bus
);

  // Wide enough for the full dimension product and for 2^ADDR_WIDTH itself.
  localparam int PW = ((2 * DATA_WIDTH_12 > ADDR_WIDTH) ? 2 * DATA_WIDTH_12 : ADDR_WIDTH) + 1;

  state_t                   state;
  logic [DATA_WIDTH_12-1:0] width_q;
  logic [DATA_WIDTH_12-1:0] height_q;
  logic [PW-1:0]            area;
  logic                     start_ok;
  logic                     clear;
  logic                     advance;
  logic [ADDR_WIDTH-1:0]    cur_addr;
  logic                     last;

  logic                     wr_en_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic [DATA_WIDTH_8-1:0]  wr_data_q;
  logic                     busy_q;
  logic                     frame_done_q;
  logic                     error_q;

  always_comb begin
    area     = PW'(bus.dst_width) * PW'(bus.dst_height);
    start_ok = (bus.dst_width != '0) && (bus.dst_height != '0) &&
               (area <= (PW'(1) << ADDR_WIDTH));
    clear    = bus.i_start && start_ok && (state != ST_DONE);
    advance  = (state == ST_COLLECT) && !bus.i_start &&
               bus.i_pixel_valid && bus.i_isreach;
  end

  resize_addr_counter #(
    .DATA_WIDTH_12(DATA_WIDTH_12),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_addr_counter (
    .clk_os (clk_os),
    .reset  (reset),
    .clear  (clear),
    .advance(advance),
    .width  (width_q),
    .height (height_q),
    .addr   (cur_addr),
    .last   (last)
  );

  always_ff @(posedge clk_os or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      width_q      <= '0;
      height_q     <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state)
        ST_IDLE, ST_COLLECT: begin
          if (bus.i_start) begin
            if (start_ok) begin
              width_q  <= bus.dst_width;
              height_q <= bus.dst_height;
              error_q  <= 1'b0;
              busy_q   <= 1'b1;
              state    <= ST_COLLECT;
            end else begin
              error_q  <= 1'b1;
              busy_q   <= 1'b0;
              state    <= ST_IDLE;
            end
          end else if (advance) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cur_addr;
            wr_data_q <= bus.i_pixel;
            if (last) begin
              busy_q <= 1'b0;
              state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          frame_done_q <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_wr_en      = wr_en_q;
  assign bus.o_wr_addr    = wr_addr_q;
  assign bus.o_wr_data    = wr_data_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = frame_done_q;
  assign bus.o_error      = error_q;

endmodule

// File: tb/tb_resize_pixel_writer.sv
// Directed self-checking bench for resize_pixel_writer.
module tb_resize_pixel_writer;

  logic clk_os = 1'b0;
  logic reset  = 1'b1;
  int   checks = 0;
  int   passes = 0;

  resize_pixel_writer_if #(.DATA_WIDTH_8(8), .DATA_WIDTH_12(12), .ADDR_WIDTH(20)) bus ();

  resize_pixel_writer #(.DATA_WIDTH_8(8), .DATA_WIDTH_12(12), .ADDR_WIDTH(20)) dut (
    .clk_os(clk_os),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_os = ~clk_os;

  task automatic cyc();
    @(posedge clk_os);
    #1;
  endtask

  task automatic drive(input logic st, input int w, input int h,
                       input logic v, input logic r, input int px);
    bus.i_start       = st;
    bus.dst_width     = 12'(w);
    bus.dst_height    = 12'(h);
    bus.i_pixel_valid = v;
    bus.i_isreach     = r;
    bus.i_pixel       = 8'(px);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_frame_done, bus.o_error} !== '0)
      $display("FAIL reset_outputs: got en=%b addr=%h data=%h busy=%b done=%b err=%b, want all 0",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_frame_done, bus.o_error);
    else passes++;
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_frame_4x2();
    drive(1, 4, 2, 0, 0, 0);
    cyc();
    checks++;
    if (bus.o_busy !== 1'b1) $display("FAIL f42_busy: got %b want 1", bus.o_busy);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      drive(0, 4, 2, 1, 1, 8'h10 + i);
      cyc();
      checks++;
      if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 20'(i) || bus.o_wr_data !== 8'(8'h10 + i))
        $display("FAIL f42_write%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                 i, bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, i, 8'h10 + i);
      else passes++;
      if (i < 7) begin
        checks++;
        if (bus.o_frame_done !== 1'b0) $display("FAIL f42_early_done: got %b want 0", bus.o_frame_done);
        else passes++;
      end
    end
    drive(0, 4, 2, 0, 0, 0);
    cyc();
    checks++;
    if (bus.o_frame_done !== 1'b1 || bus.o_wr_en !== 1'b0 || bus.o_busy !== 1'b0)
      $display("FAIL f42_done: got done=%b en=%b busy=%b want done=1 en=0 busy=0",
               bus.o_frame_done, bus.o_wr_en, bus.o_busy);
    else passes++;
    cyc();
    checks++;
    if (bus.o_frame_done !== 1'b0) $display("FAIL f42_done_pulse: got %b want 0", bus.o_frame_done);
    else passes++;
  endtask

  task automatic test_isreach_toggle();
    int writes = 0;
    int dones  = 0;
    drive(1, 2, 2, 0, 0, 0);
    cyc();
    for (int j = 0; j < 10; j++) begin
      drive(0, 2, 2, 1, (j % 2) == 0, 8'h40 + j);
      cyc();
      if (bus.o_wr_en === 1'b1) begin
        checks++;
        if (bus.o_wr_addr !== 20'(writes) || bus.o_wr_data !== 8'(8'h40 + j - 1 + 1 - ((j + 1) % 2 == 0 ? 0 : 0)))
          $display("FAIL tog_write: got addr=%0d data=%h want addr=%0d data=%h",
                   bus.o_wr_addr, bus.o_wr_data, writes, 8'h40 + j);
        else passes++;
        writes++;
      end
      if (bus.o_frame_done === 1'b1) dones++;
    end
    drive(0, 2, 2, 0, 0, 0);
    checks++;
    if (writes !== 4) $display("FAIL tog_count: got %0d writes want 4", writes);
    else passes++;
    checks++;
    if (dones !== 1) $display("FAIL tog_done: got %0d done pulses want 1", dones);
    else passes++;
  endtask

  task automatic test_error();
    int stray = 0;
    drive(1, 0, 3, 0, 0, 0);
    cyc();
    checks++;
    if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0)
      $display("FAIL err_zero: got err=%b busy=%b want err=1 busy=0", bus.o_error, bus.o_busy);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 3, 1, 1, 8'h99);
      cyc();
      if (bus.o_wr_en !== 1'b0) stray++;
    end
    checks++;
    if (stray !== 0) $display("FAIL err_nowrite: got %0d writes want 0", stray);
    else passes++;
    drive(1, 4095, 4095, 0, 0, 0);
    cyc();
    checks++;
    if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0)
      $display("FAIL err_range: got err=%b busy=%b want err=1 busy=0", bus.o_error, bus.o_busy);
    else passes++;
    drive(1, 1024, 1024, 0, 0, 0);
    cyc();
    checks++;
    if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b1)
      $display("FAIL err_full_buffer: got err=%b busy=%b want err=0 busy=1", bus.o_error, bus.o_busy);
    else passes++;
    drive(1, 5, 0, 0, 0, 0);
    cyc();
    checks++;
    if (bus.o_error !== 1'b1 || bus.o_busy !== 1'b0)
      $display("FAIL err_bad_restart: got err=%b busy=%b want err=1 busy=0", bus.o_error, bus.o_busy);
    else passes++;
    drive(1, 1, 1, 0, 0, 0);
    cyc();
    checks++;
    if (bus.o_error !== 1'b0 || bus.o_busy !== 1'b1)
      $display("FAIL err_clear: got err=%b busy=%b want err=0 busy=1", bus.o_error, bus.o_busy);
    else passes++;
    drive(0, 1, 1, 1, 1, 8'h3C);
    cyc();
    checks++;
    if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 20'd0 || bus.o_wr_data !== 8'h3C || bus.o_busy !== 1'b0)
      $display("FAIL err_1x1_write: got en=%b addr=%0d data=%h busy=%b want en=1 addr=0 data=3c busy=0",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy);
    else passes++;
    drive(0, 1, 1, 0, 0, 0);
    cyc();
    checks++;
    if (bus.o_frame_done !== 1'b1) $display("FAIL err_1x1_done: got %b want 1", bus.o_frame_done);
    else passes++;
    cyc();
  endtask

  task automatic test_restart();
    int dones = 0;
    drive(1, 4, 4, 0, 0, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      drive(0, 4, 4, 1, 1, 8'h20 + i);
      cyc();
      if (bus.o_frame_done === 1'b1) dones++;
    end
    checks++;
    if (bus.o_wr_addr !== 20'd2) $display("FAIL rst_pre_addr: got %0d want 2", bus.o_wr_addr);
    else passes++;
    drive(1, 4, 4, 0, 0, 0);
    cyc();
    if (bus.o_frame_done === 1'b1) dones++;
    drive(0, 4, 4, 1, 1, 8'h77);
    cyc();
    if (bus.o_frame_done === 1'b1) dones++;
    checks++;
    if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 20'd0 || bus.o_wr_data !== 8'h77)
      $display("FAIL restart_addr: got en=%b addr=%0d data=%h want en=1 addr=0 data=77",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
    else passes++;
    drive(0, 4, 4, 0, 0, 0);
    cyc();
    if (bus.o_frame_done === 1'b1) dones++;
    checks++;
    if (dones !== 0) $display("FAIL restart_no_done: got %0d done pulses want 0", dones);
    else passes++;
  endtask

  task automatic test_start_coincident();
    drive(1, 4, 4, 1, 1, 8'hAA);
    cyc();
    checks++;
    if (bus.o_wr_en !== 1'b0 || bus.o_busy !== 1'b1)
      $display("FAIL coinc_drop: got en=%b busy=%b want en=0 busy=1", bus.o_wr_en, bus.o_busy);
    else passes++;
    drive(0, 4, 4, 1, 1, 8'h55);
    cyc();
    checks++;
    if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 20'd0 || bus.o_wr_data !== 8'h55)
      $display("FAIL coinc_first: got en=%b addr=%0d data=%h want en=1 addr=0 data=55",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data);
    else passes++;
  endtask

  task automatic test_reset_midframe();
    int dones = 0;
    drive(0, 4, 4, 1, 1, 8'h66);
    cyc();
    checks++;
    if (bus.o_wr_en !== 1'b1 || bus.o_wr_addr !== 20'd1)
      $display("FAIL mid_pre: got en=%b addr=%0d want en=1 addr=1", bus.o_wr_en, bus.o_wr_addr);
    else passes++;
    drive(0, 4, 4, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_frame_done, bus.o_error} !== '0)
      $display("FAIL mid_async: got en=%b addr=%h data=%h busy=%b done=%b err=%b want all 0",
               bus.o_wr_en, bus.o_wr_addr, bus.o_wr_data, bus.o_busy, bus.o_frame_done, bus.o_error);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (bus.o_frame_done === 1'b1) dones++;
    end
    reset = 1'b0;
    drive(1, 2, 1, 0, 0, 0);
    cyc();
    if (bus.o_frame_done === 1'b1) dones++;
    checks++;
    if (bus.o_busy !== 1'b1) $display("FAIL mid_restart: got busy=%b want 1", bus.o_busy);
    else passes++;
    drive(0, 2, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      if (bus.o_frame_done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) $display("FAIL mid_no_done: got %0d done pulses want 0", dones);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_frame_4x2();
    test_isreach_toggle();
    test_error();
    test_restart();
    test_start_coincident();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
